// File: rtl/pipe_stage_skid_reg_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_skid_reg_if
// Brief   : Handshake/data bundle for the elastic {instr, PC} stage register.
// Revision: 1.0 - initial release
// ============================================================================
interface pipe_stage_skid_reg_if #(
  parameter int DPW = 32,
  parameter int AW  = 32,
  parameter int CW  = 16
);
  logic           valid_i;
  logic           ready_o;
  logic [DPW-1:0] instr_i;
  logic [AW-1:0]  pc_i;
  logic           stall_i;
  logic           flush_i;
  logic           valid_o;
  logic           ready_i;
  logic [DPW-1:0] instr_o;
  logic [AW-1:0]  pc_o;
  logic [CW-1:0]  stall_cnt_o;
  logic [CW-1:0]  flush_cnt_o;

  // Producer/consumer side (pipeline neighbours, hazard unit).
  modport master (
    output valid_i, instr_i, pc_i, stall_i, flush_i, ready_i,
    input  ready_o, valid_o, instr_o, pc_o, stall_cnt_o, flush_cnt_o
  );

  // The stage register itself.
  modport slave (
    input  valid_i, instr_i, pc_i, stall_i, flush_i, ready_i,
    output ready_o, valid_o, instr_o, pc_o, stall_cnt_o, flush_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_skid_reg
// Brief   : Elastic {instr, PC} pipeline register with a 2-entry skid buffer,
//           flush-to-bubble and registered ready. Optional perf counters are
//           enabled by defining the macro PSR_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_stage_skid_reg #(
  parameter int             DPW       = 32,
  parameter int             AW        = 32,
  parameter logic [DPW-1:0] NOP_INSTR = 32'h00000013,
  parameter int             CW        = 16
) (
  input  wire                    clk,
  input  wire                    rst_n,
  pipe_stage_skid_reg_if.slave   bus
);

  logic           r_mv;
  logic [DPW-1:0] r_minstr;
  logic [AW-1:0]  r_mpc;
  logic           r_sv;
  logic [DPW-1:0] r_sinstr;
  logic [AW-1:0]  r_spc;

  logic w_push;
  logic w_pop;

  // ready depends only on skid occupancy, so it is a pure register output.
  assign bus.ready_o = ~r_sv;
  assign w_push      = bus.valid_i & ~r_sv;
  assign w_pop       = r_mv & bus.ready_i & ~bus.stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mv     <= 1'b0;
      r_minstr <= NOP_INSTR;
      r_mpc    <= '0;
      r_sv     <= 1'b0;
      r_sinstr <= NOP_INSTR;
      r_spc    <= '0;
    end else if (bus.flush_i) begin
      r_mv <= 1'b0;
      r_sv <= 1'b0;
    end else if (r_sv) begin
      if (w_pop) begin
        r_minstr <= r_sinstr;
        r_mpc    <= r_spc;
        r_sv     <= 1'b0;
      end
    end else if (!r_mv) begin
      if (w_push) begin
        r_mv     <= 1'b1;
        r_minstr <= bus.instr_i;
        r_mpc    <= bus.pc_i;
      end
    end else if (w_pop) begin
      if (w_push) begin
        r_minstr <= bus.instr_i;
        r_mpc    <= bus.pc_i;
      end else begin
        r_mv <= 1'b0;
      end
    end else if (w_push) begin
      r_sv     <= 1'b1;
      r_sinstr <= bus.instr_i;
      r_spc    <= bus.pc_i;
    end
  end

  // Empty slots present a bubble rather than stale data.
  assign bus.valid_o = r_mv;
  assign bus.instr_o = r_mv ? r_minstr : NOP_INSTR;
  assign bus.pc_o    = r_mv ? r_mpc : '0;

`ifdef PSR_PERF_CNT_EN
  logic [CW-1:0] r_stall_cnt;
  logic [CW-1:0] r_flush_cnt;
  logic          w_stall_evt;
  logic          w_flush_evt;

  assign w_stall_evt = r_mv & ~(bus.ready_i & ~bus.stall_i);
  assign w_flush_evt = bus.flush_i & (r_mv | r_sv);

  // Saturating counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != {CW{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != {CW{1'b1}}))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.flush_cnt_o = r_flush_cnt;
`else
  assign bus.stall_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire
